pipelined_chunk_adder: RTL and testbench
========================================

# pipelined_chunk_adder

Parametrised, pipelined successor to the 8-bit ripple adder. It adds two WIDTH-bit operands plus carry-in. The carry chain is split into CHUNK-bit slices, one slice per pipeline stage, so WIDTH scales without lengthening the critical path. The block sits between operand producers and result consumers on valid/ready streams, sustains one addition per cycle, and stalls losslessly under backpressure.

## Interface
- WIDTH, 32, operand and sum width in bits; must be a positive multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow; present only with ADDER_OVF_EN.

## Operation
- The pipeline has STAGES registered stages. Each stage carries a valid bit, a carry, the completed low sum chunks, and the not-yet-added high operand chunks.
- Stage k adds chunk k of a and b (bits k·CHUNK+CHUNK-1 : k·CHUNK) plus the carry from stage k-1. Stage 0 uses cin as its carry.
- Global advance: adv = !out_valid || out_ready. in_ready = adv && rst_n.
- When adv = 1, every stage loads from its predecessor, and stage 0 loads {in_valid, a, b, cin}.
- When adv = 0, all stages hold.
- Bubbles are not collapsed. An invalid stage still shifts when adv = 1.
- Accept = in_valid && in_ready. Emit = out_valid && out_ready. Accept and emit in the same cycle are legal and required for full throughput.
- Results leave in acceptance order. No result is dropped or duplicated.
- sum and cout are the registered contents of the final stage. They stay stable while out_valid = 1 and out_ready = 0.
- The contents of a and b are don't-care when in_valid = 0. out_valid must never be set by an invalid beat.
- STAGES = 1 is legal: the block degenerates to a single registered full-width adder.

## Timing
- Reset, asynchronous: all stage valid bits are 0, and out_valid, sum, cout and ovf are 0. in_ready is 0 while rst_n = 0.
- in_ready is 1 on the first cycle after rst_n deasserts.
- Latency: a beat accepted on edge N appears with out_valid = 1 after edge N+STAGES-1 when there is no stall. This equals STAGES cycles from acceptance to output-registered.
- Each stall cycle (adv = 0) adds exactly one cycle of latency to every beat in flight.
- in_ready depends combinationally on out_ready. There is no other combinational path from input to output.
- Reset mid-operation discards every in-flight beat immediately. No stale result appears after reset.

## Configuration
- ADDER_OVF_EN defined:
  - Port ovf exists, registered alongside sum.
  - ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]).
  - The operand sign bits are carried down the pipeline to the final stage.
- ADDER_OVF_EN undefined:
  - Port ovf and its sign-carry registers are absent.
  - All other behaviour is identical.

## Structure
- Shared package adder_pkg holds:
  - the default CHUNK constant;
  - a function computing STAGES from WIDTH and CHUNK;
  - typedef chunk_t (logic [CHUNK-1:0]).
- A legality check (WIDTH % CHUNK == 0) is elaborated at top level.
- Sub-module adder_chunk_stage: one registered pipeline stage, parametrised by stage index. It is instantiated STAGES times in a generate loop and contains the CHUNK-bit add, valid, carry and operand/sum shift registers.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- Full-width wrap: a=32'hFFFF_FFFF, b=1, cin=0, out_ready=1 -> sum=0, cout=1, out_valid exactly STAGES (4) cycles after accept.
- Chunk-boundary carry: a=32'h0000_00FF, b=1, cin=0 -> sum=32'h0000_0100, cout=0. With a=32'h00FF_FFFF, b=0, cin=1 -> sum=32'h0100_0000.
- Streaming: 3 back-to-back beats (1+2, 3+4, 5+6, cin=0), out_ready=1 -> sums 3, 7, 11 on consecutive cycles, in order, in_ready constant 1.
- Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> sum and cout stable, in_ready=0, no accepts. Release -> all in-flight results emitted in order, none lost.
- Reset mid-flight: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately. After release, no result appears until a new beat is accepted.
- ADDER_OVF_EN:
  - 32'h7FFF_FFFF+1 -> ovf=1, cout=0.
  - 32'h8000_0000+32'h8000_0000 -> sum=0, cout=1, ovf=1.
  - 32'h7FFF_FFFF+32'h8000_0000 -> sum=32'hFFFF_FFFF, ovf=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Purpose: shared constants, types and helpers for the pipelined chunk adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

  // Default number of bits resolved per pipeline stage.
  localparam int CHUNK_DEF = 8;

  // One carry-chain slice at the default chunk size.
  typedef logic [CHUNK_DEF-1:0] chunk_t;

  // Number of pipeline stages needed to cover a WIDTH-bit add in CHUNK-bit slices.
  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// Purpose: one registered stage of the chunked adder; resolves chunk K and shifts operands/partial sum.
// Latency: 1 cycle from stage input to stage output when adv_i is high.
// Backpressure: holds all state while adv_i is low; bubbles shift like valid beats.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = CHUNK_DEF,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic             cy_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             vld_o,
  output logic             cy_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o
);

  // Bit offset of the slice this stage resolves.
  localparam int LO = K * CHUNK;

  logic [CHUNK:0]   add_w;
  logic             vld_d, cy_d;
  logic [WIDTH-1:0] sum_d;
  logic             vld_q, cy_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;

  // Add this stage's slice plus the incoming carry and splice it into the partial sum.
  always_comb begin
    add_w = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, cy_i};
    sum_d = sum_i;
    sum_d[LO +: CHUNK] = add_w[CHUNK-1:0];
    cy_d  = add_w[CHUNK];
    vld_d = vld_i;
  end

  // Stage register: cleared asynchronously, advances only with the global pipeline.
  // Operand chunks already consumed become dead bits and are trimmed by synthesis.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      cy_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else if (adv_i) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_i;
      b_q   <= b_i;
      sum_q <= sum_d;
    end
  end

  assign vld_o = vld_q;
  assign cy_o  = cy_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Purpose: WIDTH-bit a+b+cin on valid/ready streams, carry chain split into CHUNK-bit pipeline stages.
// Latency: WIDTH/CHUNK cycles from accept to registered result; one add per cycle sustained.
// Backpressure: whole pipeline stalls when the result is held; in_ready = (!out_valid || out_ready) && rst_n.
// Optional: define ADDER_OVF_EN to add the signed-overflow output ovf and its sign-bit pipeline.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  // Refuse to elaborate a width that does not split into whole chunks.
  if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Stage boundary signals; index 0 is the input port, index STAGES the final register.
  logic             vld_p [STAGES+1];
  logic             cy_p  [STAGES+1];
  logic [WIDTH-1:0] a_p   [STAGES+1];
  logic [WIDTH-1:0] b_p   [STAGES+1];
  logic [WIDTH-1:0] sum_p [STAGES+1];
  logic             adv;

  assign vld_p[0] = in_valid;
  assign cy_p[0]  = cin;
  assign a_p[0]   = a;
  assign b_p[0]   = b;
  assign sum_p[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .K     (k)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv_i (adv),
      .vld_i (vld_p[k]),
      .cy_i  (cy_p[k]),
      .a_i   (a_p[k]),
      .b_i   (b_p[k]),
      .sum_i (sum_p[k]),
      .vld_o (vld_p[k+1]),
      .cy_o  (cy_p[k+1]),
      .a_o   (a_p[k+1]),
      .b_o   (b_p[k+1]),
      .sum_o (sum_p[k+1])
    );
  end

  // Single global advance: the pipeline moves whenever the output slot is free or being drained.
  assign adv       = !vld_p[STAGES] || out_ready;
  assign in_ready  = adv && rst_n;
  assign out_valid = vld_p[STAGES];
  assign sum       = sum_p[STAGES];
  assign cout      = cy_p[STAGES];

`ifdef ADDER_OVF_EN
  logic sa_q [STAGES];
  logic sb_q [STAGES];

  // Carry the operand sign bits alongside each beat so the final stage can judge overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sa_q[i] <= 1'b0;
        sb_q[i] <= 1'b0;
      end
    end else if (adv) begin
      sa_q[0] <= a[WIDTH-1];
      sb_q[0] <= b[WIDTH-1];
      for (int i = 1; i < STAGES; i++) begin
        sa_q[i] <= sa_q[i-1];
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Overflow: like-signed operands whose sum flips sign; depends only on final-stage registers.
  assign ovf = (sa_q[STAGES-1] == sb_q[STAGES-1]) && (sum[WIDTH-1] != sa_q[STAGES-1]);
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Purpose: directed self-checking bench for pipelined_chunk_adder at WIDTH=32, CHUNK=8.
// Latency: expects results 4 cycles after accept with no stall.
// Backpressure: exercises stalls, mid-flight reset and back-to-back streaming.
module tb_pipelined_chunk_adder;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_chunk_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, let it be accepted, then wait (bounded) for its result.
  // lat counts the accept cycle as cycle 1.
  task automatic run_single(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tc, output int lat);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
`ifdef ADDER_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    int lat;
    tick();
    run_single(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    checks++; if (lat !== STAGES) begin errors++; $display("FAIL wrap_latency: got %0d want %0d", lat, STAGES); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL wrap_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b want 1", cout); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_chunk_carry();
    int lat;
    tick();
    run_single(32'h0000_00FF, 32'h1, 1'b0, lat);
    checks++; if (sum !== 32'h0000_0100) begin errors++; $display("FAIL carry8_sum: got %h want 00000100", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL carry8_cout: got %b want 0", cout); end
    run_single(32'h00FF_FFFF, 32'h0, 1'b1, lat);
    checks++; if (sum !== 32'h0100_0000) begin errors++; $display("FAIL carry24_sum: got %h want 01000000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL carry24_cout: got %b want 0", cout); end
    run_single(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL cin_wrap_sum: got %h want 0", sum); end
    checks++; if (cout !== 1'b1) begin errors++; $display("FAIL cin_wrap_cout: got %b want 1", cout); end
    checks++; if (lat !== STAGES) begin errors++; $display("FAIL cin_wrap_latency: got %0d want %0d", lat, STAGES); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got [3];
    int idx [3];
    int n = 0;
    int rdy_low = 0;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 32'(2 * i + 1);
      b = 32'(2 * i + 2);
      cin = 1'b0;
      #1;
      if (in_ready !== 1'b1) rdy_low++;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got[i] = 32'hDEAD_BEEF;
      idx[i] = -100;
    end
    for (int c = 0; c < 12; c++) begin
      if (in_ready !== 1'b1) rdy_low++;
      if (out_valid === 1'b1) begin
        if (n < 3) begin
          got[n] = sum;
          idx[n] = c;
        end
        n++;
      end
      tick();
    end
    checks++; if (rdy_low !== 0) begin errors++; $display("FAIL stream_in_ready: low on %0d cycles want 0", rdy_low); end
    checks++; if (n !== 3) begin errors++; $display("FAIL stream_count: got %0d results want 3", n); end
    checks++; if (got[0] !== 32'd3) begin errors++; $display("FAIL stream_sum0: got %h want 3", got[0]); end
    checks++; if (got[1] !== 32'd7) begin errors++; $display("FAIL stream_sum1: got %h want 7", got[1]); end
    checks++; if (got[2] !== 32'd11) begin errors++; $display("FAIL stream_sum2: got %h want b", got[2]); end
    checks++; if (idx[1] !== idx[0] + 1 || idx[2] !== idx[1] + 1) begin
      errors++; $display("FAIL stream_consecutive: cycles %0d %0d %0d want consecutive", idx[0], idx[1], idx[2]);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] va [3];
    logic [WIDTH-1:0] vb [3];
    logic             vc [3];
    logic [WIDTH-1:0] got [3];
    logic             gotc [3];
    int cyc = 0;
    int n = 0;
    int bad = 0;
    va = '{32'd10, 32'd30, 32'hFFFF_FFFF};
    vb = '{32'd20, 32'd40, 32'hFFFF_FFFF};
    vc = '{1'b0, 1'b1, 1'b0};
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = va[i];
      b = vb[i];
      cin = vc[i];
      tick();
    end
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: timed out, out_valid %b want 1", out_valid); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 32'd55;
    b = 32'd66;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_comb: got %b want 0", in_ready); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || sum !== 32'd30 || cout !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d unstable stall cycles want 0 (sum %h cout %b)", bad, sum, cout); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      got[i]  = 32'hDEAD_BEEF;
      gotc[i] = 1'bx;
    end
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) begin
        if (n < 3) begin
          got[n]  = sum;
          gotc[n] = cout;
        end
        n++;
      end
      tick();
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL bp_count: got %0d results want 3", n); end
    checks++; if (got[0] !== 32'd30 || gotc[0] !== 1'b0) begin errors++; $display("FAIL bp_res0: got %h/%b want 1e/0", got[0], gotc[0]); end
    checks++; if (got[1] !== 32'd71 || gotc[1] !== 1'b0) begin errors++; $display("FAIL bp_res1: got %h/%b want 47/0", got[1], gotc[1]); end
    checks++; if (got[2] !== 32'hFFFF_FFFE || gotc[2] !== 1'b1) begin errors++; $display("FAIL bp_res2: got %h/%b want fffffffe/1", got[2], gotc[2]); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    int lat;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      a = 32'(100 * i);
      b = 32'(i);
      cin = 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || sum !== 32'd101) begin errors++; $display("FAIL mid_pre: got %b/%h want 1/65", out_valid, sum); end
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL mid_sum: got %h want 0", sum); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale: %0d cycles with out_valid want 0", seen); end
    run_single(32'd7, 32'd8, 1'b0, lat);
    checks++; if (sum !== 32'd15 || lat !== STAGES) begin errors++; $display("FAIL mid_after: got sum %h lat %0d want f lat %0d", sum, lat, STAGES); end
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    int lat;
    tick();
    run_single(32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    checks++; if (ovf !== 1'b1 || cout !== 1'b0 || sum !== 32'h8000_0000) begin
      errors++; $display("FAIL ovf_pos: got ovf %b cout %b sum %h want 1 0 80000000", ovf, cout, sum);
    end
    run_single(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    checks++; if (ovf !== 1'b1 || cout !== 1'b1 || sum !== 32'h0) begin
      errors++; $display("FAIL ovf_neg: got ovf %b cout %b sum %h want 1 1 0", ovf, cout, sum);
    end
    run_single(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, lat);
    checks++; if (ovf !== 1'b0 || sum !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL ovf_mixed: got ovf %b sum %h want 0 ffffffff", ovf, sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_chunk_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
